uart_rx_param: RTL

Parametrised UART receive engine, the next-generation serial receiver for the LOA serial path. Configurable frame format (5–8 data bits, none/even/odd parity, 1 or 2 stop bits) and baud divisor. Built-in input synchroniser, false-start rejection, mid-bit sampling and a valid/ready output holding register with parity, framing and overrun reporting. Sits between the board `rx` pin and the command/packet parser.

---
 rtl/uart_rx_param.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// UART receive engine: two-flop line synchroniser, false-start rejection,
// mid-bit sampling of a configurable frame, and a valid/ready holding
// register that reports parity, framing and overrun conditions.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | line idle, waiting for a 1->0 transition on the synced line
// S_START   | counting to the middle of the start bit; high there = glitch
// S_DATA    | shifting in DATA_BITS samples, LSB first
// S_PARITY  | sampling the parity bit (skipped when PARITY = 0)
// S_STOP    | sampling STOP_BITS stop bits; any low marks a framing error
// S_DELIVER | one cycle: hand the frame to the holding register or drop it
module uart_rx_param #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 9600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int BIT_CNT = CLK_FREQ / BAUD;
   localparam int HALF    = BIT_CNT / 2;
   localparam int CNT_W   = $clog2(BIT_CNT);

   // The counter wraps at CNT_LAST; loading CNT_LOAD on start detect makes
   // the first wrap (the start-bit sample) land HALF cycles later.
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(BIT_CNT - HALF);
   localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DELIVER
   } state_t;

   state_t                 state;
   state_t                 state_nx;

   logic                   s1;
   logic                   s2;
   logic                   prev;
   logic [CNT_W-1:0]       cnt;
   logic [2:0]             bit_idx;
   logic                   stop_idx;
   logic [DATA_BITS-1:0]   shift_reg;
   logic                   perr_q;
   logic                   ferr_q;

   logic                   tick;
   logic                   start_det;
   logic                   par_xor;
   logic                   par_bad;

   assign tick      = (cnt == CNT_LAST);
   assign start_det = prev & ~s2;
   assign busy      = (state != S_IDLE);

   // Parity over the shifted-in word plus the received parity bit;
   // even parity expects the total to be 0, odd parity expects 1.
   assign par_xor = (^shift_reg) ^ s2;
   assign par_bad = (PARITY == 1) ? par_xor : ~par_xor;

   // Two-flop synchroniser and one-cycle history for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1   <= 1'b1;
         s2   <= 1'b1;
         prev <= 1'b0;
      end else begin
         s1   <= rx_in;
         s2   <= s1;
         prev <= s2;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // FSM next-state logic; every transition except IDLE->START and
   // DELIVER->IDLE happens on a sample tick.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (start_det) state_nx = S_START;
         end
         S_START: begin
            if (tick) state_nx = s2 ? S_IDLE : S_DATA;
         end
         S_DATA: begin
            if (tick && (bit_idx == LAST_BIT))
               state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (tick) state_nx = S_STOP;
         end
         S_STOP: begin
            if (tick && (stop_idx == LAST_STOP)) state_nx = S_DELIVER;
         end
         S_DELIVER: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Bit-period counter: parked at 0 in IDLE, preloaded on start detect,
   // free-running with wrap while a frame is in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (state == S_IDLE) begin
         cnt <= start_det ? CNT_LOAD : '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Frame assembly: data shift register, bit/stop indices and the
   // per-frame error flags, all cleared while idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_idx   <= '0;
         stop_idx  <= 1'b0;
         shift_reg <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               bit_idx  <= '0;
               stop_idx <= 1'b0;
               perr_q   <= 1'b0;
               ferr_q   <= 1'b0;
            end
            S_DATA: begin
               if (tick) begin
                  shift_reg <= {s2, shift_reg[DATA_BITS-1:1]};
                  bit_idx   <= bit_idx + 3'd1;
               end
            end
            S_PARITY: begin
               if (tick) perr_q <= par_bad;
            end
            S_STOP: begin
               if (tick) begin
                  if (!s2) ferr_q <= 1'b1;
                  stop_idx <= stop_idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Holding register: a frame is accepted when the register is empty or
   // being emptied in the same cycle, otherwise it is dropped and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (state == S_DELIVER) begin
            if (!rx_valid || rx_ready) begin
               rx_data    <= shift_reg;
               parity_err <= perr_q;
               frame_err  <= ferr_q;
               rx_valid   <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
